// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, 1-cycle imem issue, DEPTH-entry instr FIFO with redirect flush; FETCH_QUEUE_STATS_EN adds stat counters
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcplus4
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0] stat_bubbles,
  output logic [31:0] stat_flushes
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0] fetch_pc, inflight_pc, head_pc;
  logic inflight, push, pop;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  // issue only with a free slot for the in-flight return; flush/reset mask issue and pop
  always_comb begin
    imem_req = ~reset & ~redirect & ((count + {{AW{1'b0}}, inflight}) < FULL);
    imem_addr = fetch_pc;
    out_valid = (count != '0) & ~redirect & ~reset;
    push = inflight & ~redirect & ~reset;
    pop = out_valid & out_ready;
    head_pc = pc_q[rd_ptr];
    out_instr = out_valid ? instr_q[rd_ptr] : '0;
    out_pc = out_valid ? head_pc : '0;
    out_pcplus4 = out_valid ? head_pc + 32'd4 : '0;
  end
  // FIFO storage: returning instruction lands with the PC it was fetched from
  always_ff @(posedge clock) begin
    if (push) begin
      instr_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr] <= inflight_pc;
    end
  end
  // fetch PC, in-flight tracking and FIFO occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      inflight <= imem_req;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
`ifdef FETCH_QUEUE_STATS_EN
  // saturating bubble and non-empty-flush counters
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_bubbles <= '0;
      stat_flushes <= '0;
    end else begin
      if (out_ready & ~out_valid & (stat_bubbles != '1)) stat_bubbles <= stat_bubbles + 32'd1;
      if (redirect & ((count != '0) | inflight) & (stat_flushes != '1)) stat_flushes <= stat_flushes + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue ordering, backpressure, redirect, wrap, reset and stats
module tb_fetch_queue;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic redirect = 1'b0;
  logic out_ready = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic ready1 = 1'b1;
  logic redir1 = 1'b0;
  logic [31:0] rpc1 = '0;
  logic [31:0] rdata0, rdata1, addr0, addr1, instr0, instr1, pc0, pc1, p40, p41;
  logic req0, req1, v0, v1;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] bub0, fl0, bub1, fl1;
`endif
  int n_tests = 0;
  int n_fail = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u0 (
    .clock(clock), .reset(reset), .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(v0), .out_ready(out_ready),
    .out_instr(instr0), .out_pc(pc0), .out_pcplus4(p40)
`ifdef FETCH_QUEUE_STATS_EN
    , .stat_bubbles(bub0), .stat_flushes(fl0)
`endif
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u1 (
    .clock(clock), .reset(reset), .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
    .redirect(redir1), .redirect_pc(rpc1), .out_valid(v1), .out_ready(ready1),
    .out_instr(instr1), .out_pc(pc1), .out_pcplus4(p41)
`ifdef FETCH_QUEUE_STATS_EN
    , .stat_bubbles(bub1), .stat_flushes(fl1)
`endif
  );

  always #5 clock = ~clock;

  // 1-cycle instruction memory: returns addr | 0x1000
  always @(posedge clock) begin
    rdata0 <= addr0 | 32'h1000;
    rdata1 <= addr1 | 32'h1000;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  // a return must never land in a full FIFO
  always @(negedge clock)
    if (!reset && !redirect && u0.inflight)
      chk("no_overflow", {31'b0, u0.count < 4}, 32'd1);

  initial begin
    cyc;
    cyc;
    #1;
    chk("rst_req", {31'b0, req0}, 32'd0);
    chk("rst_valid", {31'b0, v0}, 32'd0);
    chk("rst_instr", instr0, 32'd0);
    reset = 1'b0;
    #1;
    chk("c0_req", {31'b0, req0}, 32'd1);
    chk("c0_addr", addr0, 32'h0);
    chk("c0_valid", {31'b0, v0}, 32'd0);
    cyc;
    #1;
    chk("c1_addr", addr0, 32'h4);
    chk("c1_valid", {31'b0, v0}, 32'd0);
    cyc;
    #1;
    chk("c2_addr", addr0, 32'h8);
    chk("c2_valid", {31'b0, v0}, 32'd1);
    chk("c2_pc", pc0, 32'h0);
    chk("c2_instr", instr0, 32'h1000);
    chk("c2_pc4", p40, 32'h4);
    chk("wrap_pc0", pc1, 32'hFFFF_FFF8);
    cyc;
    #1;
    chk("c3_pc", pc0, 32'h4);
    chk("c3_instr", instr0, 32'h1004);
    chk("wrap_pc1", pc1, 32'hFFFF_FFFC);
    chk("wrap_pc4", p41, 32'h0);
    cyc;
    #1;
    chk("c4_pc", pc0, 32'h8);
    chk("wrap_pc2", pc1, 32'h0);
    chk("wrap_instr2", instr1, 32'h1000);
    chk("wrap_pc4_2", p41, 32'h4);
    cyc;
    out_ready = 1'b0;
    repeat (9) cyc;
    #1;
    chk("full_req", {31'b0, req0}, 32'd0);
    chk("full_valid", {31'b0, v0}, 32'd1);
    chk("full_head", pc0, 32'hC);
    cyc;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_pc", pc0, 32'hC + 32'(4 * k));
      chk("drain_instr", instr0, (32'hC + 32'(4 * k)) | 32'h1000);
      cyc;
      #1;
    end
    out_ready = 1'b0;
    cyc;
    redirect = 1'b1;
    redirect_pc = 32'h43;
    out_ready = 1'b1;
    #1;
    chk("redir_valid", {31'b0, v0}, 32'd0);
    chk("redir_req", {31'b0, req0}, 32'd0);
    cyc;
    redirect = 1'b0;
    #1;
    chk("post_redir_valid", {31'b0, v0}, 32'd0);
    chk("post_redir_addr", addr0, 32'h40);
    chk("post_redir_req", {31'b0, req0}, 32'd1);
    cyc;
    #1;
    chk("redir_e1_valid", {31'b0, v0}, 32'd0);
    cyc;
    #1;
    chk("redir_e2_valid", {31'b0, v0}, 32'd1);
    chk("redir_e2_pc", pc0, 32'h40);
    chk("redir_e2_instr", instr0, 32'h1040);
    out_ready = 1'b0;
    cyc;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, v0}, 32'd0);
    chk("mid_rst_req", {31'b0, req0}, 32'd0);
    cyc;
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst2_valid", {31'b0, v0}, 32'd0);
    chk("rst2_addr", addr0, 32'h0);
    cyc;
    #1;
    chk("rst2_e1_valid", {31'b0, v0}, 32'd0);
    cyc;
    #1;
    chk("rst2_pc", pc0, 32'h0);
    chk("rst2_instr", instr0, 32'h1000);
    cyc;
    #1;
    chk("rst2_pc_next", pc0, 32'h4);
`ifdef FETCH_QUEUE_STATS_EN
    reset = 1'b1;
    cyc;
    cyc;
    #1;
    chk("stat_rst_bub", bub0, 32'd0);
    chk("stat_rst_fl", fl0, 32'd0);
    reset = 1'b0;
    redirect = 1'b1;
    out_ready = 1'b1;
    repeat (5) cyc;
    redirect = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("stat_bub5", bub0, 32'd5);
    chk("stat_fl_empty", fl0, 32'd0);
    repeat (3) cyc;
    redirect = 1'b1;
    cyc;
    redirect = 1'b0;
    repeat (2) cyc;
    redirect = 1'b1;
    cyc;
    redirect = 1'b0;
    #1;
    chk("stat_bub_final", bub0, 32'd5);
    chk("stat_fl_final", fl0, 32'd2);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
